// File: rtl/soc_event_arbiter.sv
// Event arbiter: latches single-cycle peripheral event pulses into pending bits and
// drains them round-robin, one event ID per transfer, into the FC event FIFO port.
module soc_event_arbiter #(
  parameter int NB_EVENTS      = 32,
  parameter int EVENT_ID_WIDTH = 8,
  parameter int ID_OFFSET      = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NB_EVENTS-1:0]      events_i,
  output logic                      event_fifo_valid_o,
  input  logic                      event_fifo_fulln_i,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
  output logic [NB_EVENTS-1:0]      pending_o,
  output logic                      overflow_o
);

  localparam int PTR_W = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1;

  // Reject configurations whose IDs cannot be represented or whose source count is out of range
  if (NB_EVENTS < 1 || NB_EVENTS > 256) begin : g_bad_nb_events
    $fatal(1, "soc_event_arbiter: NB_EVENTS must be in 1..256");
  end
  if (NB_EVENTS + ID_OFFSET > (2 ** EVENT_ID_WIDTH)) begin : g_bad_id_range
    $fatal(1, "soc_event_arbiter: NB_EVENTS + ID_OFFSET exceeds the event ID range");
  end

  logic [NB_EVENTS-1:0]      pending;
  logic [PTR_W-1:0]          rr_ptr;
  logic                      out_valid;
  logic [EVENT_ID_WIDTH-1:0] out_id;
  logic                      overflow_q;

  logic                      out_free;
  logic                      grant_en;
  logic                      grant_found;
  logic [PTR_W-1:0]          grant_idx;
  logic [NB_EVENTS-1:0]      grant_vec;
  logic [NB_EVENTS-1:0]      pending_next;
  logic                      overflow_next;
  int                        search_idx;

  assign out_free = ~out_valid | event_fifo_fulln_i;
  assign grant_en = out_free & (|pending);

  // First pending source at or after rr_ptr, wrapping past the top index
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = 0;
    for (int k = 0; k < NB_EVENTS; k++) begin
      search_idx = int'(rr_ptr) + k;
      if (search_idx >= NB_EVENTS) begin
        search_idx = search_idx - NB_EVENTS;
      end
      if (!grant_found && pending[PTR_W'(search_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(search_idx);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_en) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  // A pulse on a granted source re-arms it, so only non-granted pending sources can drop
  assign pending_next  = (pending & ~grant_vec) | events_i;
  assign overflow_next = |(events_i & pending & ~grant_vec);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending    <= pending_next;
      overflow_q <= overflow_next;
    end
  end

  // Output register only changes when the previous ID has been taken or none was offered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (out_free) begin
      if (grant_en) begin
        out_valid <= 1'b1;
        out_id    <= EVENT_ID_WIDTH'(int'(grant_idx) + ID_OFFSET);
        if (grant_idx == PTR_W'(NB_EVENTS - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_idx + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign event_fifo_valid_o = out_valid;
  assign event_fifo_data_o  = out_id;
  assign pending_o          = pending;
  assign overflow_o         = overflow_q;

endmodule
